// File: rtl/mini_top_sw_led.sv
// rtl/mini_top_sw_led.sv - switch-selected LED pattern generator (off/blink/run/count)
module mini_top_sw_led #(
  parameter int LED_W    = 8,
  parameter int TICK_DIV = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_sw,
  output logic [LED_W-1:0] o_led
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_RUN   = 2'd2,
    MODE_COUNT = 2'd3
  } mode_t;

  logic [1:0]       sync_q1;
  logic [1:0]       sync_q2;
  mode_t            mode;
  logic [PW-1:0]    prescaler;
  logic [LED_W-1:0] pattern;
  logic             tick;

  assign tick  = (prescaler == PRESC_LAST);
  assign o_led = pattern;

  function automatic logic [LED_W-1:0] initial_pattern(input mode_t m);
    logic [LED_W-1:0] p;
    p = '0;
    case (m)
      MODE_BLINK: p = '1;
      MODE_RUN:   p = LED_W'(1);
      default:    p = '0;
    endcase
    return p;
  endfunction

  function automatic logic [LED_W-1:0] next_pattern(input mode_t m, input logic [LED_W-1:0] p);
    logic [LED_W-1:0] n;
    n = p;
    case (m)
      MODE_OFF:   n = '0;
      MODE_BLINK: n = ~p;
      MODE_RUN:   n = {p[LED_W-2:0], p[LED_W-1]};
      MODE_COUNT: n = p + LED_W'(1);
      default:    n = '0;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1   <= '0;
      sync_q2   <= '0;
      mode      <= MODE_OFF;
      prescaler <= '0;
      pattern   <= '0;
    end else begin
      sync_q1 <= i_sw;
      sync_q2 <= sync_q1;
      // A mode change restarts the pattern and wins over a coincident tick.
      if (sync_q2 != mode) begin
        mode      <= mode_t'(sync_q2);
        prescaler <= '0;
        pattern   <= initial_pattern(mode_t'(sync_q2));
      end else begin
        prescaler <= tick ? '0 : prescaler + PW'(1);
        if (tick) begin
          pattern <= next_pattern(mode, pattern);
        end
      end
    end
  end

endmodule

// File: tb/tb_mini_top_sw_led.sv
// tb/tb_mini_top_sw_led.sv - directed scoreboard bench for mini_top_sw_led
module tb_mini_top_sw_led;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] i_sw;
  logic [7:0] o_led;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  mini_top_sw_led #(.LED_W(8), .TICK_DIV(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_sw  (i_sw),
    .o_led (o_led)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input int n, input string tag, input logic [7:0] exp);
    logic [7:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    step(n);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (o_led === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", t, o_led, e);
    end
  endtask

  initial begin
    logic [7:0] run;
    rst  = 1'b1;
    i_sw = 2'd0;

    // Reset and idle in mode 0
    for (int i = 0; i < 10; i++) step_chk(10, "reset", 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step_chk(10, "idle_off", 8'h00);

    // Blink: 0xFF on third edge, toggles every 16 cycles
    i_sw = 2'd1;
    step_chk(2, "blink_latency_pre", 8'h00);
    step_chk(1, "blink_entry", 8'hFF);
    step_chk(15, "blink_hold", 8'hFF);
    step_chk(1, "blink_off", 8'h00);
    step_chk(16, "blink_on", 8'hFF);
    step_chk(16, "blink_off2", 8'h00);

    // Running light with wrap after 8 steps
    i_sw = 2'd2;
    step_chk(3, "run_entry", 8'h01);
    run = 8'h01;
    for (int i = 0; i < 8; i++) begin
      step_chk(15, "run_hold", run);
      run = {run[6:0], run[7]};
      step_chk(1, "run_step", run);
    end

    // A glitch that is never sampled must not restart the pattern
    step(5);
    i_sw = 2'd1;
    #3;
    i_sw = 2'd2;
    step_chk(10, "glitch_hold", 8'h01);
    step_chk(1, "glitch_step", 8'h02);

    // Counter through full wrap
    i_sw = 2'd3;
    step_chk(3, "cnt_entry", 8'h00);
    for (int k = 1; k < 256; k++) step_chk(16, "cnt_step", 8'(k));
    step_chk(16, "cnt_wrap", 8'h00);

    // Mode switch mid-prescale restarts the prescaler
    step_chk(16 * 7, "cnt_at7", 8'h07);
    step(5);
    i_sw = 2'd2;
    step_chk(2, "sw32_pre", 8'h07);
    step_chk(1, "sw32_entry", 8'h01);
    step_chk(15, "sw32_hold", 8'h01);
    step_chk(1, "sw32_step", 8'h02);
    step_chk(16, "run_04", 8'h04);
    step_chk(16, "run_08", 8'h08);
    step_chk(16, "run_10", 8'h10);

    // One-cycle reset during mode 2
    step(3);
    rst = 1'b1;
    step_chk(1, "rst_mid", 8'h00);
    vectors++;
    assert (dut.mode === 2'd0) else begin
      miscompares++;
      $error("FAIL rst_mode: observed %0d expected 0", dut.mode);
    end
    rst = 1'b0;
    step_chk(2, "post_rst_pre", 8'h00);
    step_chk(1, "post_rst_entry", 8'h01);

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mini_top_sw_led.md
Name: mini_top_sw_led

Overview:
Switch-controlled LED pattern generator for the mini top-level demo. A 2-bit switch input selects one of four display modes: off, blink, running light, or binary counter. The patterns advance on a programmable prescaler tick. The block synchronises the asynchronous switch input and drives a registered LED bus.

Parameters:
LED_W, 8, width of o_led; legal range 2..32.
TICK_DIV, 16, clock cycles per pattern step; legal value ≥2; prescaler counter width is clog2(TICK_DIV).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous active-high reset.
i_sw  input  2  mode-select switches; asynchronous to clk, no debounce required.
o_led  output  LED_W  registered LED drive; 1 = LED on.

Behaviour:
Interface: one clock; reset is synchronous and active-high.
- Reset:
  - While rst=1 at a rising edge, clear sync_q1, sync_q2, mode, prescaler and pattern, so o_led=0 and mode=0.
  - Reset asserted mid-operation takes effect at the next edge and overrides everything else.
- Switch synchroniser:
  - Two-flop chain: sync_q1 <= i_sw; sync_q2 <= sync_q1.
  - No debounce or filtering. A value stable across one sampling edge propagates.
- Mode register (2 bits):
  - When sync_q2 != mode: mode <= sync_q2, prescaler <= 0, pattern <= the new mode's initial value.
  - Mode entry takes priority over a coincident tick.
- Latency: i_sw first sampled new at edge N; o_led shows the new mode's initial pattern after edge N+2 (3 edges inclusive).
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 in the cycle the count equals TICK_DIV-1.
  - First pattern step occurs TICK_DIV cycles after mode entry.
- Modes. Each line gives the initial value, then the update applied on each tick:
  - 0 off: all zeros; stays all zeros.
  - 1 blink: all ones; pattern <= ~pattern (all-ones / all-zeros alternation).
  - 2 running light: one-hot LSB (0x01); rotate left by 1, MSB wraps to LSB (0x80 -> 0x01 for LED_W=8).
  - 3 counter: zero; pattern <= pattern+1, modulo 2^LED_W (0xFF -> 0x00).
- Output: o_led = pattern register directly, with no combinational path from i_sw.
- Same-value switch activity: if i_sw returns to the current mode before reaching sync_q2, mode does not change and the prescaler and pattern are not restarted.
- Re-selecting a mode after a different mode always restarts that mode from its initial value.

Test Plan:
1. Reset for 100 cycles with i_sw=0, then release → o_led=0x00 throughout. After release, o_led stays 0x00 indefinitely.
2. i_sw 0→1 → o_led=0xFF on the 3rd edge. Then 0x00 after 16 more cycles, then 0xFF after 16 more, alternating every 16 cycles.
3. i_sw →2 → o_led=0x01, then 0x02, 0x04 … 0x80, 0x01 at 16-cycle intervals. Wrap confirmed after 8 steps.
4. i_sw →3, held 4200 cycles → o_led=0x00,0x01,0x02… Reaches 0xFF after 255 ticks (4080 cycles), then 0x00 at the next tick.
5. i_sw 3→2 when the prescaler is at 5 and o_led=0x07 → 3 edges later o_led=0x01 and the prescaler is 0. Next change occurs 16 cycles later (0x02).
6. Assert rst for 1 cycle during mode 2 with o_led=0x10 → next edge o_led=0x00 and mode=0. With i_sw=2 still applied, o_led=0x01 on the 3rd edge after rst deasserts.
